// File: rtl/rf_defs_pkg.sv
// Shared register-file defaults and type aliases for the core and the bench.
package rf_defs;

   localparam int unsigned RF_XLEN = 32;
   localparam int unsigned RF_NREG = 32;
   localparam int unsigned RF_AW   = $clog2(RF_NREG);

   typedef logic [RF_XLEN-1:0] rf_word_t;
   typedef logic [RF_AW-1:0]   rf_addr_t;

endpackage : rf_defs

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, any write clears, issue wins a same-cycle tie.
module rf_scoreboard
   import rf_defs::*;
#(
   parameter int unsigned NREG   = RF_NREG,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [NREG-1:0] wr_hit;
   logic [NREG-1:0] iss_hit;

   // Decode this cycle's write targets and issue target; register 0 is never tracked.
   always_comb begin
      wr_hit  = '0;
      iss_hit = '0;
      for (int unsigned k = 0; k < NWR; k++) begin
         if (wr_en[k]) wr_hit[wr_addr[k*AW +: AW]] = 1'b1;
      end
      if (iss_en) iss_hit[iss_addr] = 1'b1;
      wr_hit[0]  = 1'b0;
      iss_hit[0] = 1'b0;
      busy_nxt   = (busy & ~wr_hit) | iss_hit;
   end

   // Busy bit storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // Per-port busy view, hiding a producer that is completing in this very cycle.
   for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
      logic [AW-1:0] ra;
      logic          masked;
      assign ra       = rd_addr[p*AW +: AW];
      assign masked   = (BYPASS != 0) && wr_hit[ra] && !iss_hit[ra];
      assign rd_busy[p] = !rst && busy[ra] && !masked;
   end

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hardwired to zero, optional write bypass and busy scoreboard.
module regfile_mp
   import rf_defs::*;
#(
   parameter int unsigned XLEN   = RF_XLEN,
   parameter int unsigned NREG   = RF_NREG,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr
);

   logic [XLEN-1:0] mem [NREG];

   // Register array; ports applied in ascending order so the highest index wins a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) mem[r] <= '0;
      end else begin
         for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
               mem[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
         end
      end
   end

   // Zero-latency read ports with optional same-cycle forwarding from the write ports.
   for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      assign ra = rd_addr[p*AW +: AW];

      // Array value, overridden by the highest-indexed matching write when bypassing.
      always_comb begin
         rv = (ra == '0) ? '0 : mem[ra];
         if (BYPASS != 0) begin
            for (int unsigned k = 0; k < NWR; k++) begin
               if (wr_en[k] && (ra != '0) && (wr_addr[k*AW +: AW] == ra))
                  rv = wr_data[k*XLEN +: XLEN];
            end
         end
      end

      assign rd_data[p*XLEN +: XLEN] = rst ? '0 : rv;
   end

   rf_scoreboard #(
      .NREG   (NREG),
      .NRD    (NRD),
      .NWR    (NWR),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy)
   );

endmodule : regfile_mp
